// File: rtl/b_instr_if.sv
// Bus between the fetch stage and the B-type decoder: instruction in, decoded fields out.
interface b_instr_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic [31:0]     instr_word;
    logic            out_valid;
    logic [6:0]      imm_b_msb;
    logic [4:0]      rs2;
    logic [4:0]      rs1;
    logic [2:0]      funct3;
    logic [4:0]      imm_b_lsb;
    logic [12:0]     imm_b;
    logic [XLEN-1:0] imm_b_sext;
    logic            is_branch;
    logic            illegal;
    logic [5:0]      br_onehot;

    // Fetch side: drives the instruction word, consumes the decode.
    modport master (
        output in_valid, instr_word,
        input  out_valid, imm_b_msb, rs2, rs1, funct3, imm_b_lsb, imm_b, imm_b_sext,
               is_branch, illegal, br_onehot
    );

    // Decoder side.
    modport slave (
        input  in_valid, instr_word,
        output out_valid, imm_b_msb, rs2, rs1, funct3, imm_b_lsb, imm_b, imm_b_sext,
               is_branch, illegal, br_onehot
    );
endinterface

// File: rtl/b_instr.sv
// Registered RV32I B-type decoder: raw field split, branch offset assembly,
// sign extension and one-hot branch-kind decode, one cycle of latency.
module b_instr #(
    parameter int unsigned XLEN = 32
) (
    input logic      clk,
    input logic      rst_n,
    b_instr_if.slave bus
);
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic            valid_q;
    logic [6:0]      msb_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rs1_q;
    logic [2:0]      funct3_q;
    logic [4:0]      lsb_q;
    logic [12:0]     imm_q;
    logic [XLEN-1:0] sext_q;
    logic            is_branch_q;
    logic            illegal_q;
    logic [5:0]      onehot_q;

    logic [12:0]     imm_d;
    logic [XLEN-1:0] sext_d;
    logic            is_branch_d;
    logic            illegal_d;
    logic [5:0]      onehot_d;

    // Offset assembly and branch-kind decode from the incoming word.
    always_comb begin
        imm_d       = {bus.instr_word[31], bus.instr_word[7], bus.instr_word[30:25],
                       bus.instr_word[11:8], 1'b0};
        sext_d      = XLEN'($signed(imm_d));
        is_branch_d = 1'b0;
        illegal_d   = 1'b0;
        onehot_d    = '0;
        if (bus.instr_word[6:0] == OpBranch) begin
            unique case (bus.instr_word[14:12])
                3'b000:         onehot_d = 6'b000001;  // beq
                3'b001:         onehot_d = 6'b000010;  // bne
                3'b100:         onehot_d = 6'b000100;  // blt
                3'b101:         onehot_d = 6'b001000;  // bge
                3'b110:         onehot_d = 6'b010000;  // bltu
                3'b111:         onehot_d = 6'b100000;  // bgeu
                3'b010, 3'b011: illegal_d = 1'b1;
            endcase
            is_branch_d = ~illegal_d;
        end
    end

    // Output registers: load on in_valid, otherwise hold; valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            msb_q       <= '0;
            rs2_q       <= '0;
            rs1_q       <= '0;
            funct3_q    <= '0;
            lsb_q       <= '0;
            imm_q       <= '0;
            sext_q      <= '0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            onehot_q    <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                msb_q       <= bus.instr_word[31:25];
                rs2_q       <= bus.instr_word[24:20];
                rs1_q       <= bus.instr_word[19:15];
                funct3_q    <= bus.instr_word[14:12];
                lsb_q       <= bus.instr_word[11:7];
                imm_q       <= imm_d;
                sext_q      <= sext_d;
                is_branch_q <= is_branch_d;
                illegal_q   <= illegal_d;
                onehot_q    <= onehot_d;
            end
        end
    end

    // Drive the bus straight from the registers.
    always_comb begin
        bus.out_valid  = valid_q;
        bus.imm_b_msb  = msb_q;
        bus.rs2        = rs2_q;
        bus.rs1        = rs1_q;
        bus.funct3     = funct3_q;
        bus.imm_b_lsb  = lsb_q;
        bus.imm_b      = imm_q;
        bus.imm_b_sext = sext_q;
        bus.is_branch  = is_branch_q;
        bus.illegal    = illegal_q;
        bus.br_onehot  = onehot_q;
    end
endmodule

// File: tb/tb_b_instr.sv
// Scoreboard bench for b_instr: stimulus pushes model predictions, a negedge
// monitor pops and compares whenever out_valid is high and checks hold otherwise.
module tb_b_instr;
    typedef struct packed {
        logic [6:0]  msb;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [4:0]  lsb;
        logic [12:0] imm;
        logic [31:0] sext;
        logic        br;
        logic        ill;
        logic [5:0]  oh;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last = '0;

    b_instr_if #(.XLEN(32)) bus ();

    b_instr #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference decode from the instruction-set rules, using plain arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        int unsigned u;
        int unsigned f3;
        int unsigned imm;
        int          s;
        u     = w;
        f3    = (u >> 12) % 8;
        e.msb = 7'((u >> 25) % 128);
        e.rs2 = 5'((u >> 20) % 32);
        e.rs1 = 5'((u >> 15) % 32);
        e.f3  = 3'(f3);
        e.lsb = 5'((u >> 7) % 32);
        imm   = ((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
              + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
        e.imm = 13'(imm);
        s     = (imm >= 4096) ? int'(imm) - 8192 : int'(imm);
        e.sext = 32'(s);
        e.br  = 1'b0;
        e.ill = 1'b0;
        e.oh  = '0;
        if (u % 128 == 99) begin
            if (f3 == 2 || f3 == 3) begin
                e.ill = 1'b1;
            end else begin
                e.br = 1'b1;
                e.oh = 6'(1 << ((f3 < 2) ? f3 : f3 - 2));
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".imm_b_msb"},  64'(bus.imm_b_msb),  64'(e.msb));
        chk({tag, ".rs2"},        64'(bus.rs2),        64'(e.rs2));
        chk({tag, ".rs1"},        64'(bus.rs1),        64'(e.rs1));
        chk({tag, ".funct3"},     64'(bus.funct3),     64'(e.f3));
        chk({tag, ".imm_b_lsb"},  64'(bus.imm_b_lsb),  64'(e.lsb));
        chk({tag, ".imm_b"},      64'(bus.imm_b),      64'(e.imm));
        chk({tag, ".imm_b_sext"}, 64'(bus.imm_b_sext), 64'(e.sext));
        chk({tag, ".is_branch"},  64'(bus.is_branch),  64'(e.br));
        chk({tag, ".illegal"},    64'(bus.illegal),    64'(e.ill));
        chk({tag, ".br_onehot"},  64'(bus.br_onehot),  64'(e.oh));
    endtask

    task automatic send(input logic [31:0] w);
        bus.in_valid   = 1'b1;
        bus.instr_word = w;
        sb.push_back(model(w));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        cmp_all(tag, '0);
    endtask

    // Monitor: pop on every presented decode; otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            last = '0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                last = sb.pop_front();
                cmp_all("dec", last);
            end
        end else begin
            cmp_all("hold", last);
        end
    end

    logic [31:0] v2, v3, v4, w;

    initial begin
        v2 = {7'b0000111, 5'b10101, 5'b01101, 3'b111, 5'b01101, 7'b1100011};
        v3 = {7'b1010101, 5'b11100, 5'b00110, 3'b100, 5'b11101, 7'b1100011};
        v4 = {7'b1000100, 5'b00100, 5'b10111, 3'b000, 5'b11111, 7'b1100011};
        bus.in_valid   = 1'b0;
        bus.instr_word = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back known vectors, then hold.
        send(v2);
        chk("v2.out_valid", 64'(bus.out_valid), 64'd1);
        chk("v2.imm_b_msb", 64'(bus.imm_b_msb), 64'h07);
        chk("v2.rs2", 64'(bus.rs2), 64'd21);
        chk("v2.rs1", 64'(bus.rs1), 64'd13);
        chk("v2.funct3", 64'(bus.funct3), 64'd7);
        chk("v2.imm_b_lsb", 64'(bus.imm_b_lsb), 64'd13);
        chk("v2.imm_b", 64'(bus.imm_b), 64'h08EC);
        chk("v2.imm_b_sext", 64'(bus.imm_b_sext), 64'h0000_08EC);
        chk("v2.br_onehot", 64'(bus.br_onehot), 64'b100000);
        send(v3);
        chk("v3.out_valid", 64'(bus.out_valid), 64'd1);
        chk("v3.imm_b_msb", 64'(bus.imm_b_msb), 64'h55);
        chk("v3.rs2", 64'(bus.rs2), 64'd28);
        chk("v3.rs1", 64'(bus.rs1), 64'd6);
        chk("v3.imm_b_lsb", 64'(bus.imm_b_lsb), 64'd29);
        chk("v3.imm_b", 64'(bus.imm_b), 64'h1ABC);
        chk("v3.imm_b_sext", 64'(bus.imm_b_sext), 64'hFFFF_FABC);
        chk("v3.br_onehot", 64'(bus.br_onehot), 64'b000100);
        send(v4);
        chk("v4.out_valid", 64'(bus.out_valid), 64'd1);
        chk("v4.imm_b_msb", 64'(bus.imm_b_msb), 64'h44);
        chk("v4.rs2", 64'(bus.rs2), 64'd4);
        chk("v4.rs1", 64'(bus.rs1), 64'd23);
        chk("v4.imm_b_lsb", 64'(bus.imm_b_lsb), 64'd31);
        chk("v4.imm_b", 64'(bus.imm_b), 64'h189E);
        chk("v4.imm_b_sext", 64'(bus.imm_b_sext), 64'hFFFF_F89E);
        chk("v4.br_onehot", 64'(bus.br_onehot), 64'b000001);
        idle();
        chk("held.out_valid", 64'(bus.out_valid), 64'd0);
        chk("held.imm_b", 64'(bus.imm_b), 64'h189E);
        chk("held.br_onehot", 64'(bus.br_onehot), 64'b000001);
        idle();

        // Illegal funct3, then a non-branch opcode.
        send(32'hABCD_A0E3);
        chk("ill.illegal", 64'(bus.illegal), 64'd1);
        chk("ill.is_branch", 64'(bus.is_branch), 64'd0);
        chk("ill.br_onehot", 64'(bus.br_onehot), 64'd0);
        send(32'h00C5_8533);
        chk("op.is_branch", 64'(bus.is_branch), 64'd0);
        chk("op.illegal", 64'(bus.illegal), 64'd0);
        chk("op.rs1", 64'(bus.rs1), 64'd11);
        chk("op.rs2", 64'(bus.rs2), 64'd12);
        idle();

        // Random words, half forced to the branch opcode, with random gaps.
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[6:0] = 7'b1100011;
            if ($urandom_range(0, 3) == 0) idle();
            send(w);
        end

        // Reset asserted mid-stream clears outputs without a clock edge.
        send(v3);
        chk("mid.out_valid_before", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        idle();
        chk("post_rst.out_valid", 64'(bus.out_valid), 64'd0);
        send(v4);
        chk("post_rst.first_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst.imm_b", 64'(bus.imm_b), 64'h189E);
        idle();
        idle();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
